// File: rtl/mod_sel_pkg.sv
// ============================================================================
//  Module      : mod_sel_pkg
//  Description : Shared types and widths for the stream selector.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package mod_sel_pkg;

  typedef enum logic [1:0] {
    SEL_RUN   = 2'd0,
    SEL_DRAIN = 2'd1,
    SEL_GAP   = 2'd2
  } sel_state_e;

  localparam int GAP_CNT_W = 4;
  localparam int SW_CNT_W  = 16;

endpackage

`default_nettype wire

// File: rtl/mod_out_reg.sv
// ============================================================================
//  Module      : mod_out_reg
//  Description : One-entry valid/ready output register.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module mod_out_reg #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             i_load,
  input  logic [WIDTH-1:0] i_data,
  input  logic             i_ready,
  output logic [WIDTH-1:0] o_data,
  output logic             o_valid,
  output logic             o_free
);

  logic [WIDTH-1:0] r_data;
  logic             r_valid;

  // Free when empty or when the held beat leaves this cycle.
  assign o_free  = !r_valid || i_ready;
  assign o_data  = r_data;
  assign o_valid = r_valid;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_data  <= '0;
      r_valid <= 1'b0;
    end else if (i_load) begin
      r_data  <= i_data;
      r_valid <= 1'b1;
    end else if (r_valid && i_ready) begin
      r_valid <= 1'b0;
    end
  end

endmodule

`default_nettype wire

// File: rtl/mod_stream_selector.sv
// ============================================================================
//  Module      : mod_stream_selector
//  Description : Routes one of NUM_SRC valid/ready streams to a registered
//                output, switching via drain + idle gap. Optional switch
//                counter port swCount when MOD_SEL_STATS_EN is defined.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module mod_stream_selector
  import mod_sel_pkg::*;
#(
  parameter int WIDTH   = 8,
  parameter int NUM_SRC = 4,
  parameter int SEL_W   = $clog2(NUM_SRC),
  parameter int SW_GAP  = 2
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [NUM_SRC*WIDTH-1:0] srcData,
  input  logic [NUM_SRC-1:0]       srcValid,
  output logic [NUM_SRC-1:0]       srcReady,
  input  logic                     selReq,
  input  logic [SEL_W-1:0]         selIdx,
  output logic                     selAck,
  output logic                     selErr,
  output logic [SEL_W-1:0]         curSel,
  output logic [WIDTH-1:0]         outData,
  output logic                     outValid,
  input  logic                     outReady
`ifdef MOD_SEL_STATS_EN
  ,output logic [SW_CNT_W-1:0]     swCount
`endif
);

  localparam logic [1:0]           c_ST_RUN   = SEL_RUN;
  localparam logic [1:0]           c_ST_DRAIN = SEL_DRAIN;
  localparam logic [1:0]           c_ST_GAP   = SEL_GAP;
  localparam logic [SEL_W:0]       c_NUM_SRC  = (SEL_W+1)'(NUM_SRC);
  localparam logic [GAP_CNT_W-1:0] c_GAP_LOAD = GAP_CNT_W'(SW_GAP);

  logic [1:0]           r_state;
  logic [SEL_W-1:0]     r_cur_sel;
  logic [SEL_W-1:0]     r_pend_sel;
  logic [GAP_CNT_W-1:0] r_gap_cnt;
  logic                 r_sel_ack;
  logic                 r_sel_err;

  logic [WIDTH-1:0]     w_sel_data;
  logic                 w_sel_valid;
  logic                 w_idx_bad;
  logic                 w_idx_same;
  logic                 w_switch;
  logic                 w_accept;
  logic                 w_load;
  logic                 w_out_free;
  logic                 w_gap_done;

  always_comb begin
    w_sel_data  = '0;
    w_sel_valid = 1'b0;
    for (int k = 0; k < NUM_SRC; k++) begin
      if (r_cur_sel == SEL_W'(k)) begin
        w_sel_data  = srcData[k*WIDTH +: WIDTH];
        w_sel_valid = srcValid[k];
      end
    end
  end

  // Widened compare keeps the out-of-range check meaningful for any NUM_SRC.
  assign w_idx_bad  = {1'b0, selIdx} >= c_NUM_SRC;
  assign w_idx_same = (selIdx == r_cur_sel);
  assign w_switch   = (r_state == c_ST_RUN) && selReq && !w_idx_bad && !w_idx_same;
  assign w_accept   = !rst && (r_state == c_ST_RUN) && !w_switch && w_out_free;
  assign w_load     = w_accept && w_sel_valid;
  assign w_gap_done = (r_gap_cnt <= GAP_CNT_W'(1));

  generate
    for (genvar k = 0; k < NUM_SRC; k++) begin : g_ready
      assign srcReady[k] = w_accept && (r_cur_sel == SEL_W'(k));
    end
  endgenerate

  mod_out_reg #(
    .WIDTH (WIDTH)
  ) u_out_reg (
    .clk     (clk),
    .rst     (rst),
    .i_load  (w_load),
    .i_data  (w_sel_data),
    .i_ready (outReady),
    .o_data  (outData),
    .o_valid (outValid),
    .o_free  (w_out_free)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state    <= c_ST_RUN;
      r_cur_sel  <= '0;
      r_pend_sel <= '0;
      r_gap_cnt  <= '0;
      r_sel_ack  <= 1'b0;
      r_sel_err  <= 1'b0;
    end else begin
      r_sel_ack <= 1'b0;
      r_sel_err <= 1'b0;
      case (r_state)
        c_ST_RUN: begin
          if (selReq) begin
            if (w_idx_bad) begin
              r_sel_err <= 1'b1;
            end else if (w_idx_same) begin
              r_sel_ack <= 1'b1;
            end else begin
              r_pend_sel <= selIdx;
              r_state    <= c_ST_DRAIN;
            end
          end
        end
        c_ST_DRAIN: begin
          if (w_out_free) begin
            r_gap_cnt <= c_GAP_LOAD;
            r_state   <= c_ST_GAP;
          end
        end
        c_ST_GAP: begin
          // A zero or one count both finish here, so a zero gap is one cycle.
          if (w_gap_done) begin
            r_cur_sel <= r_pend_sel;
            r_sel_ack <= 1'b1;
            r_gap_cnt <= '0;
            r_state   <= c_ST_RUN;
          end else begin
            r_gap_cnt <= r_gap_cnt - GAP_CNT_W'(1);
          end
        end
        default: r_state <= c_ST_RUN;
      endcase
    end
  end

  assign selAck = r_sel_ack;
  assign selErr = r_sel_err;
  assign curSel = r_cur_sel;

`ifdef MOD_SEL_STATS_EN
  logic [SW_CNT_W-1:0] r_sw_count;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_sw_count <= '0;
    end else if ((r_state == c_ST_GAP) && w_gap_done && (r_sw_count != '1)) begin
      r_sw_count <= r_sw_count + SW_CNT_W'(1);
    end
  end

  assign swCount = r_sw_count;
`endif

endmodule

`default_nettype wire

// File: tb/tb_mod_stream_selector.sv
// ============================================================================
//  Module      : tb_mod_stream_selector
//  Description : Directed bench for mod_stream_selector (optionally with
//                MOD_SEL_STATS_EN for the swCount port).
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_mod_stream_selector;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] srcData;
  logic [3:0]  srcValid;
  logic [3:0]  srcReady;
  logic        selReq;
  logic [1:0]  selIdx;
  logic        selAck;
  logic        selErr;
  logic [1:0]  curSel;
  logic [7:0]  outData;
  logic        outValid;
  logic        outReady;

  logic [23:0] s3_srcData;
  logic [2:0]  s3_srcValid;
  logic [2:0]  s3_srcReady;
  logic        s3_selReq;
  logic [1:0]  s3_selIdx;
  logic        s3_selAck;
  logic        s3_selErr;
  logic [1:0]  s3_curSel;
  logic [7:0]  s3_outData;
  logic        s3_outValid;
  logic        s3_outReady;

`ifdef MOD_SEL_STATS_EN
  logic [15:0] swCount;
  logic [15:0] s3_swCount;
`endif

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  mod_stream_selector #(.WIDTH(8), .NUM_SRC(4), .SW_GAP(2)) u_dut (
    .clk      (clk),
    .rst      (rst),
    .srcData  (srcData),
    .srcValid (srcValid),
    .srcReady (srcReady),
    .selReq   (selReq),
    .selIdx   (selIdx),
    .selAck   (selAck),
    .selErr   (selErr),
    .curSel   (curSel),
    .outData  (outData),
    .outValid (outValid),
    .outReady (outReady)
`ifdef MOD_SEL_STATS_EN
    ,.swCount (swCount)
`endif
  );

  mod_stream_selector #(.WIDTH(8), .NUM_SRC(3), .SW_GAP(2)) u_dut3 (
    .clk      (clk),
    .rst      (rst),
    .srcData  (s3_srcData),
    .srcValid (s3_srcValid),
    .srcReady (s3_srcReady),
    .selReq   (s3_selReq),
    .selIdx   (s3_selIdx),
    .selAck   (s3_selAck),
    .selErr   (s3_selErr),
    .curSel   (s3_curSel),
    .outData  (s3_outData),
    .outValid (s3_outValid),
    .outReady (s3_outReady)
`ifdef MOD_SEL_STATS_EN
    ,.swCount (s3_swCount)
`endif
  );

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h required 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

`ifdef MOD_SEL_STATS_EN
  task automatic do_switch(input logic [1:0] idx);
    logic seen;
    seen   = 1'b0;
    selReq = 1'b1;
    selIdx = idx;
    cyc();
    selReq = 1'b0;
    for (int i = 0; i < 20 && !seen; i++) begin
      if (selAck) seen = 1'b1;
      else cyc();
    end
    check_val("sw_ack_seen", 32'(seen), 32'd1);
  endtask
`endif

  initial begin
    rst = 1'b1;
    srcData = '0; srcValid = '0; selReq = 1'b0; selIdx = '0; outReady = 1'b0;
    s3_srcData = '0; s3_srcValid = '0; s3_selReq = 1'b0; s3_selIdx = '0; s3_outReady = 1'b1;

    // Reset state
    cyc();
    cyc();
    check_val("rst_srcReady", 32'(srcReady), 32'h0);
    check_val("rst_outValid", 32'(outValid), 32'h0);
    check_val("rst_outData",  32'(outData),  32'h0);
    check_val("rst_curSel",   32'(curSel),   32'h0);
    check_val("rst_selAck",   32'(selAck),   32'h0);
    check_val("rst_selErr",   32'(selErr),   32'h0);

    // Stream 0x11,0x22,0x33 from src0
    rst = 1'b0;
    outReady = 1'b1;
    srcValid = 4'b0001;
    srcData[7:0] = 8'h11;
    #1 check_val("str_ready0", 32'(srcReady), 32'h1);
    cyc();
    check_val("str_d11", 32'(outData), 32'h11);
    check_val("str_v11", 32'(outValid), 32'h1);
    srcData[7:0] = 8'h22;
    #1 check_val("str_ready1", 32'(srcReady), 32'h1);
    cyc();
    check_val("str_d22", 32'(outData), 32'h22);
    srcData[7:0] = 8'h33;
    cyc();
    check_val("str_d33", 32'(outData), 32'h33);
    srcValid = 4'b0000;
    cyc();
    check_val("str_v_end", 32'(outValid), 32'h0);
    check_val("str_hold", 32'(outData), 32'h33);

    // Back-pressure
    outReady = 1'b0;
    srcValid = 4'b0001;
    srcData[7:0] = 8'h44;
    cyc();
    check_val("bp_d44", 32'(outData), 32'h44);
    srcData[7:0] = 8'h55;
    #1 check_val("bp_ready_low", 32'(srcReady), 32'h0);
    cyc();
    cyc();
    check_val("bp_stable_d", 32'(outData), 32'h44);
    check_val("bp_stable_v", 32'(outValid), 32'h1);
    outReady = 1'b1;
    #1 check_val("bp_ready_up", 32'(srcReady), 32'h1);
    cyc();
    check_val("bp_d55", 32'(outData), 32'h55);
    srcValid = 4'b0000;
    cyc();

    // Same-index request: ack next cycle, no stall
    selReq = 1'b1; selIdx = 2'd0;
    srcValid = 4'b0001; srcData[7:0] = 8'h5A;
    #1 check_val("same_ready", 32'(srcReady), 32'h1);
    cyc();
    check_val("same_ack", 32'(selAck), 32'h1);
    check_val("same_data", 32'(outData), 32'h5A);
    check_val("same_cur", 32'(curSel), 32'h0);
    selReq = 1'b0; srcValid = 4'b0000;
    cyc();
    check_val("same_ack_off", 32'(selAck), 32'h0);

    // Switch to src2 with back-pressure for 3 cycles
    outReady = 1'b0;
    srcValid = 4'b0001; srcData[7:0] = 8'h66;
    cyc();
    srcValid = 4'b0100; srcData[23:16] = 8'hA2;
    selReq = 1'b1; selIdx = 2'd2;
    #1 check_val("sw_ready_drop", 32'(srcReady), 32'h0);
    cyc();
    selReq = 1'b0;
    check_val("sw_drain_ack", 32'(selAck), 32'h0);
    cyc();
    cyc();
    check_val("sw_drain_d", 32'(outData), 32'h66);
    check_val("sw_drain_v", 32'(outValid), 32'h1);
    outReady = 1'b1;
    #1 check_val("sw_drain_ready", 32'(srcReady), 32'h0);
    cyc();
    check_val("sw_gap1_v", 32'(outValid), 32'h0);
    check_val("sw_gap1_ack", 32'(selAck), 32'h0);
    check_val("sw_gap1_ready", 32'(srcReady), 32'h0);
    cyc();
    check_val("sw_gap2_ack", 32'(selAck), 32'h0);
    check_val("sw_gap2_cur", 32'(curSel), 32'h0);
    cyc();
    check_val("sw_ack", 32'(selAck), 32'h1);
    check_val("sw_cur2", 32'(curSel), 32'h2);
    check_val("sw_ready2", 32'(srcReady), 32'h4);
    cyc();
    check_val("sw_dA2", 32'(outData), 32'hA2);
    check_val("sw_ack_off", 32'(selAck), 32'h0);

    // Switch 2->1 with a free output: ready must drop in the request cycle
    srcData[23:16] = 8'hB2;
    selReq = 1'b1; selIdx = 2'd1;
    #1 check_val("sw21_ready_drop", 32'(srcReady), 32'h0);
    cyc();
    selReq = 1'b0; srcValid = 4'b0000;
    check_val("sw21_no_load", 32'(outData), 32'hA2);
    check_val("sw21_v", 32'(outValid), 32'h0);
    cyc();
    cyc();
    check_val("sw21_gap_ack", 32'(selAck), 32'h0);
    cyc();
    check_val("sw21_ack", 32'(selAck), 32'h1);
    check_val("sw21_cur", 32'(curSel), 32'h1);

    // Reset during GAP aborts the switch
    selReq = 1'b1; selIdx = 2'd3;
    cyc();
    selReq = 1'b0;
    cyc();
    rst = 1'b1;
    cyc();
    check_val("rsw_cur", 32'(curSel), 32'h0);
    check_val("rsw_v", 32'(outValid), 32'h0);
    check_val("rsw_ack", 32'(selAck), 32'h0);
    rst = 1'b0;
    cyc();
    check_val("rsw_ack2", 32'(selAck), 32'h0);
    check_val("rsw_cur2", 32'(curSel), 32'h0);
    srcValid = 4'b0001; srcData[7:0] = 8'h77;
    #1 check_val("rsw_ready0", 32'(srcReady), 32'h1);
    cyc();
    check_val("rsw_d77", 32'(outData), 32'h77);
    srcValid = 4'b0000;
    cyc();

    // Out-of-range index on the 3-source instance
    s3_selReq = 1'b1; s3_selIdx = 2'd3;
    cyc();
    s3_selReq = 1'b0;
    check_val("err_pulse", 32'(s3_selErr), 32'h1);
    check_val("err_no_ack", 32'(s3_selAck), 32'h0);
    check_val("err_cur", 32'(s3_curSel), 32'h0);
    cyc();
    check_val("err_off", 32'(s3_selErr), 32'h0);

`ifdef MOD_SEL_STATS_EN
    check_val("cnt_after_rst", 32'(swCount), 32'h0);
    do_switch(2'd1);
    do_switch(2'd2);
    do_switch(2'd3);
    do_switch(2'd3);
    cyc();
    check_val("cnt_three", 32'(swCount), 32'h3);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

`default_nettype wire
